atri_i2c_wb_arbiter: RTL and testbench
======================================

ATRI_I2C_WB_ARBITER -- requirements
Module: atri_i2c_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles a strobed access waits for ack before abort (range 1-255).
REQ-002 SHALL have port clk_i, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, the reset: synchronous, active-high.
REQ-004 SHALL have ports m0_cyc_i/m1_cyc_i, input, 1, the WISHBONE cycle request per master (m0 = PicoBlaze, m1 = hardware sequencer).
REQ-005 SHALL have ports mN_stb_i, input, 1, the strobe per master.
REQ-006 SHALL have ports mN_we_i, input, 1, the write enable per master.
REQ-007 SHALL have ports mN_adr_i, input, 3, the register address per master.
REQ-008 SHALL have ports mN_dat_i, input, 8, the write data per master.
REQ-009 SHALL have ports mN_lock_i, input, 1, the hold-ownership request (START..STOP span) per master.
REQ-010 SHALL have ports mN_dat_o, output, 8, the read data per master.
REQ-011 SHALL have ports mN_ack_o, output, 1, the acknowledge per master.
REQ-012 SHALL have ports mN_err_o, output, 1, the timeout abort pulse per master.
REQ-013 SHALL have ports mN_inta_o, output, 1, the routed I2C interrupt per master.
REQ-014 SHALL have ports s_cyc_o, s_stb_o and s_we_o, output, 1 each, the signals to the i2c_master_top slave.
REQ-015 SHALL have ports s_adr_o (output, 3) and s_dat_o (output, 8), the address and write data to the slave.
REQ-016 SHALL have ports s_dat_i (input, 8), s_ack_i (input, 1) and s_inta_i (input, 1), the slave read data, ack and interrupt.
REQ-017 SHALL have port owner_o, output, 2, for debug: 00 = idle, 01 = m0, 10 = m1.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, OWN0 and OWN1.
REQ-019 In IDLE, SHALL move to OWNn on the next edge when mN_cyc_i is high; if both request, the master not served last wins (round-robin). The first winner after reset SHALL be m0.
REQ-020 In OWNn, SHALL drive all s_* outputs combinationally from mN_*; the non-owner's ack_o, err_o and dat_o SHALL be 0.
REQ-021 s_cyc_o and s_stb_o SHALL be 0 in IDLE.
REQ-022 SHALL pass s_ack_i and s_dat_i combinationally to the owner only, adding no latency beyond the 1-cycle grant.
REQ-023 In OWNn, SHALL return to IDLE on the edge where mN_cyc_i = 0 and mN_lock_i = 0.
REQ-024 While mN_lock_i = 1, SHALL hold ownership with cyc low, so that a multi-access I2C transaction is never interleaved.
REQ-025 SHALL use an 8-bit wait counter that increments each cycle the owner has stb high and s_ack_i low, and clears on ack or in IDLE.
REQ-026 When the wait counter reaches TIMEOUT: mN_err_o SHALL pulse for 1 cycle, s_cyc_o and s_stb_o SHALL be forced low that cycle, and the FSM SHALL go to IDLE regardless of lock.
REQ-027 A timed-out master SHALL lose round-robin priority for the next arbitration.
REQ-028 SHALL route s_inta_i to the current owner's inta_o; in IDLE, to the last owner.
REQ-029 A cyc request from the non-owner SHALL wait with no ack and no error.
REQ-030 An ack arriving in the same cycle as a timeout SHALL be treated as ack: no error, counter cleared.

Reset
REQ-031 On rst_i high at a clock edge: state = IDLE, last owner = m1 (so m0 wins first), wait counter = 0, and all outputs 0 except the combinational pass-throughs, which are 0 in IDLE.
REQ-032 A reset in mid-transaction SHALL drop s_cyc_o on the following cycle and issue no err_o.

Structure
REQ-033 SHALL place the FSM state encodings and the owner_o codes in a shared package (atri_i2c_pkg); TIMEOUT remains a module parameter.
REQ-034 SHALL be a single module with no sub-module; the round-robin pick SHALL be inline logic.

Verification
REQ-035 Request m0 alone for a write to adr 3 with data 0x5A and an immediate ack -> owner_o = 01 one cycle after cyc; s_adr_o = 3; s_dat_o = 0x5A; m0_ack_o follows s_ack_i.
REQ-036 Assert m0 and m1 cyc in the same cycle after reset -> m0 granted first; m1 granted the cycle after m0 releases; the next tie goes to m0.
REQ-037 m1 holds lock_i = 1 over three accesses while m0 requests -> m0 is not granted until one cycle after m1 drops lock and cyc; m0 sees no error.
REQ-038 TIMEOUT = 4 and the slave never acks -> m0_err_o pulses on the 4th wait cycle, s_cyc_o is low that cycle, and owner_o = 00 next.
REQ-039 s_inta_i rises while m1 owns, then m1 releases -> m1_inta_o stays high through IDLE and m0_inta_o stays 0.
REQ-040 Assert rst_i during an m0 locked transaction -> owner_o = 00 and s_cyc_o = 0 after the edge; no err_o.

Source files
------------

// File: rtl/atri_i2c_pkg.sv
// Shared encodings for the I2C WISHBONE arbiter: FSM state codes and the
// owner debug codes (the state encoding doubles as the owner code).
package atri_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/atri_i2c_wb_arbiter.sv
// Two-master round-robin WISHBONE arbiter in front of i2c_master_top, with
// lock-based ownership hold and a per-access ack timeout.
module atri_i2c_wb_arbiter
  import atri_i2c_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [2:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  input  logic       m0_lock_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  output logic       m0_inta_o,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [2:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  input  logic       m1_lock_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       m1_inta_o,
  output logic       s_cyc_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [2:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  input  logic       s_inta_i,
  output logic [1:0] owner_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  arb_state_e state, next_state;
  logic       last_m1;
  logic       last_vld;
  logic [7:0] wait_cnt;

  logic       own0, own1;
  logic       o_cyc, o_stb, o_we, o_lock;
  logic [2:0] o_adr;
  logic [7:0] o_dat;
  logic       timeout;

  assign own0 = (state == ST_OWN0);
  assign own1 = (state == ST_OWN1);

  always_comb begin
    o_cyc  = 1'b0;
    o_stb  = 1'b0;
    o_we   = 1'b0;
    o_lock = 1'b0;
    o_adr  = '0;
    o_dat  = '0;
    if (own0) begin
      o_cyc  = m0_cyc_i;
      o_stb  = m0_stb_i;
      o_we   = m0_we_i;
      o_lock = m0_lock_i;
      o_adr  = m0_adr_i;
      o_dat  = m0_dat_i;
    end else if (own1) begin
      o_cyc  = m1_cyc_i;
      o_stb  = m1_stb_i;
      o_we   = m1_we_i;
      o_lock = m1_lock_i;
      o_adr  = m1_adr_i;
      o_dat  = m1_dat_i;
    end
  end

  // An ack landing on the last wait cycle wins; reset suppresses the abort.
  assign timeout = (own0 | own1) & o_stb & ~s_ack_i & (wait_cnt == TO_LAST) & ~rst_i;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) next_state = last_m1 ? ST_OWN0 : ST_OWN1;
        else if (m0_cyc_i)        next_state = ST_OWN0;
        else if (m1_cyc_i)        next_state = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (timeout || (!o_cyc && !o_lock)) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      last_m1  <= 1'b1;
      last_vld <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      // A timed-out master stays recorded as last served, so it loses the next tie.
      if (state == ST_IDLE && next_state != ST_IDLE) begin
        last_m1  <= (next_state == ST_OWN1);
        last_vld <= 1'b1;
      end
      if (state == ST_IDLE || timeout || s_ack_i) wait_cnt <= '0;
      else if (o_stb)                             wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    s_cyc_o   = o_cyc & ~timeout;
    s_stb_o   = o_stb & ~timeout;
    s_we_o    = o_we;
    s_adr_o   = o_adr;
    s_dat_o   = o_dat;
    m0_dat_o  = own0 ? s_dat_i : 8'h00;
    m1_dat_o  = own1 ? s_dat_i : 8'h00;
    m0_ack_o  = own0 & s_ack_i;
    m1_ack_o  = own1 & s_ack_i;
    m0_err_o  = own0 & timeout;
    m1_err_o  = own1 & timeout;
    m0_inta_o = s_inta_i & (own0 | (state == ST_IDLE && last_vld && !last_m1));
    m1_inta_o = s_inta_i & (own1 | (state == ST_IDLE && last_vld &&  last_m1));
    case (state)
      ST_OWN0: owner_o = OWNER_M0;
      ST_OWN1: owner_o = OWNER_M1;
      default: owner_o = OWNER_IDLE;
    endcase
  end

endmodule

// File: tb/tb_atri_i2c_wb_arbiter.sv
// Scoreboard bench for atri_i2c_wb_arbiter: directed traffic pushes expected
// output snapshots; a negedge monitor compares on every ack/err/owner event.
module tb_atri_i2c_wb_arbiter;

  typedef struct packed {
    logic [1:0] own;
    logic [1:0] ack;
    logic [1:0] err;
    logic       cyc;
    logic       stb;
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] inta;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m0_lock = 0;
  logic m1_cyc = 0, m1_stb = 0, m1_we = 0, m1_lock = 0;
  logic [2:0] m0_adr = 0, m1_adr = 0;
  logic [7:0] m0_dat = 0, m1_dat = 0;
  logic [7:0] sdat = 8'hC3;
  logic       ack_en = 1'b0;
  logic       inta = 1'b0;

  logic [7:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic       m0_ack_o, m0_err_o, m0_inta_o;
  logic       m1_ack_o, m1_err_o, m1_inta_o;
  logic       s_cyc_o, s_stb_o, s_we_o, s_ack;
  logic [2:0] s_adr_o;
  logic [1:0] owner_o;

  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];
  string name_q[$];
  logic  armed = 1'b0;
  logic [1:0] prev_owner = 2'b00;

  // Slave model acks from the master side to avoid a combinational loop.
  assign s_ack = ack_en & ((owner_o == 2'b01 && m0_stb) || (owner_o == 2'b10 && m1_stb));

  atri_i2c_wb_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_lock_i(m0_lock), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_inta_o(m0_inta_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_lock_i(m1_lock), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_inta_o(m1_inta_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(sdat), .s_ack_i(s_ack), .s_inta_i(inta),
    .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(string name, logic [1:0] own, logic [1:0] ack, logic [1:0] err,
                      logic cyc, logic stb, logic we, logic [2:0] adr, logic [7:0] dat,
                      logic [7:0] d0, logic [7:0] d1, logic [1:0] inta);
    snap_t s;
    s = '{own: own, ack: ack, err: err, cyc: cyc, stb: stb, we: we, adr: adr,
          dat: dat, d0: d0, d1: d1, inta: inta};
    exp_q.push_back(s);
    name_q.push_back(name);
  endtask

  task automatic push_idle(string name, logic [1:0] inta_exp);
    push(name, 2'b00, 2'b00, 2'b00, 0, 0, 0, 3'd0, 8'h00, 8'h00, 8'h00, inta_exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(logic cyc, logic stb, logic we, logic [2:0] adr, logic [7:0] dat, logic lock);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_lock = lock;
  endtask

  task automatic set_m1(logic cyc, logic stb, logic we, logic [2:0] adr, logic [7:0] dat, logic lock);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_lock = lock;
  endtask

  always @(negedge clk) begin
    snap_t act, exp;
    string nm;
    if (armed) begin
      act = {owner_o, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, s_cyc_o, s_stb_o, s_we_o,
             s_adr_o, s_dat_o, m0_dat_o, m1_dat_o, m1_inta_o, m0_inta_o};
      if (m0_ack_o || m1_ack_o || m0_err_o || m1_err_o || owner_o != prev_owner) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %h expected no event", act);
        end else begin
          exp = exp_q.pop_front();
          nm  = name_q.pop_front();
          check(nm, 64'(act), 64'(exp));
        end
      end
      prev_owner = owner_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_owner", 64'(owner_o), 64'(2'b00));
    check("rst_scyc",  64'({s_cyc_o, s_stb_o}), 64'(2'b00));
    check("rst_ack_err", 64'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 64'(4'b0000));
    prev_owner = owner_o;
    armed = 1'b1;

    // single m0 write, immediate ack
    ack_en = 1'b1;
    push("a_grant_ack", 2'b01, 2'b01, 2'b00, 1, 1, 1, 3'd3, 8'h5A, 8'hC3, 8'h00, 2'b00);
    set_m0(1, 1, 1, 3'd3, 8'h5A, 0);
    tick(); tick();
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("a_release", 2'b00);
    tick(); tick();

    // tie after reset: m0, then m1, then m0, then m1
    rst = 1'b1; tick(); rst = 1'b0; tick();
    push("b_tie1_m0", 2'b01, 2'b01, 2'b00, 1, 1, 1, 3'd1, 8'h11, 8'hC3, 8'h00, 2'b00);
    set_m0(1, 1, 1, 3'd1, 8'h11, 0);
    set_m1(1, 1, 0, 3'd2, 8'h22, 0);
    tick(); tick();
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("b_m0_release", 2'b00);
    push("b_m1_after", 2'b10, 2'b10, 2'b00, 1, 1, 0, 3'd2, 8'h22, 8'h00, 8'hC3, 2'b00);
    tick(); tick(); tick();
    set_m1(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("b_m1_release", 2'b00);
    tick();
    set_m0(1, 1, 1, 3'd1, 8'h11, 0);
    set_m1(1, 1, 0, 3'd2, 8'h22, 0);
    push("b_tie2_m0", 2'b01, 2'b01, 2'b00, 1, 1, 1, 3'd1, 8'h11, 8'hC3, 8'h00, 2'b00);
    tick(); tick();
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    set_m1(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("b_tie2_release", 2'b00);
    tick();
    set_m0(1, 1, 1, 3'd1, 8'h11, 0);
    set_m1(1, 1, 0, 3'd2, 8'h22, 0);
    push("b_tie3_m1", 2'b10, 2'b10, 2'b00, 1, 1, 0, 3'd2, 8'h22, 8'h00, 8'hC3, 2'b00);
    tick(); tick();
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    set_m1(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("b_tie3_release", 2'b00);
    tick(); tick();

    // m1 locked over three accesses while m0 waits
    sdat = 8'h3C;
    push("c_m1_acc1", 2'b10, 2'b10, 2'b00, 1, 1, 1, 3'd4, 8'h44, 8'h00, 8'h3C, 2'b00);
    set_m1(1, 1, 1, 3'd4, 8'h44, 1);
    tick(); tick();
    set_m1(0, 0, 1, 3'd4, 8'h44, 1);
    set_m0(1, 1, 0, 3'd5, 8'h55, 0);
    tick();
    push("c_m1_acc2", 2'b10, 2'b10, 2'b00, 1, 1, 1, 3'd6, 8'h66, 8'h00, 8'h3C, 2'b00);
    set_m1(1, 1, 1, 3'd6, 8'h66, 1);
    tick();
    set_m1(0, 0, 1, 3'd6, 8'h66, 1);
    tick();
    push("c_m1_acc3", 2'b10, 2'b10, 2'b00, 1, 1, 1, 3'd7, 8'h77, 8'h00, 8'h3C, 2'b00);
    set_m1(1, 1, 1, 3'd7, 8'h77, 1);
    tick();
    set_m1(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("c_m1_unlock", 2'b00);
    tick();
    push("c_m0_granted", 2'b01, 2'b01, 2'b00, 1, 1, 0, 3'd5, 8'h55, 8'h3C, 8'h00, 2'b00);
    tick(); tick();
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("c_m0_release", 2'b00);
    tick(); tick();

    // timeout with a silent slave (TIMEOUT = 4)
    sdat = 8'hC3;
    ack_en = 1'b0;
    push("d_grant", 2'b01, 2'b00, 2'b00, 1, 1, 0, 3'd2, 8'hA5, 8'hC3, 8'h00, 2'b00);
    push("d_timeout_err", 2'b01, 2'b00, 2'b01, 0, 0, 0, 3'd2, 8'hA5, 8'hC3, 8'h00, 2'b00);
    push_idle("d_abort_idle", 2'b00);
    set_m0(1, 1, 0, 3'd2, 8'hA5, 0);
    tick(); tick(); tick(); tick(); tick();
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    tick();
    ack_en = 1'b1;
    push("d_tie_after_to", 2'b10, 2'b10, 2'b00, 1, 1, 1, 3'd1, 8'h99, 8'h00, 8'hC3, 2'b00);
    set_m0(1, 1, 0, 3'd2, 8'hA5, 0);
    set_m1(1, 1, 1, 3'd1, 8'h99, 0);
    tick(); tick();
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    set_m1(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("d_tie_release", 2'b00);
    tick(); tick();

    // ack on the final wait cycle beats the timeout
    ack_en = 1'b0;
    push("d_late_grant", 2'b01, 2'b00, 2'b00, 1, 1, 1, 3'd3, 8'h12, 8'hC3, 8'h00, 2'b00);
    push("d_late_ack", 2'b01, 2'b01, 2'b00, 1, 1, 1, 3'd3, 8'h12, 8'hC3, 8'h00, 2'b00);
    set_m0(1, 1, 1, 3'd3, 8'h12, 0);
    tick(); tick(); tick(); tick();
    ack_en = 1'b1;
    tick();
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("d_late_release", 2'b00);
    tick(); tick();

    // interrupt follows m1 into idle
    push("e_m1_grant", 2'b10, 2'b10, 2'b00, 1, 1, 0, 3'd6, 8'h00, 8'h00, 8'hC3, 2'b00);
    set_m1(1, 1, 0, 3'd6, 8'h00, 0);
    tick(); tick();
    set_m1(1, 0, 0, 3'd6, 8'h00, 0);
    inta = 1'b1;
    tick();
    set_m1(0, 0, 0, 3'd0, 8'h00, 0);
    push_idle("e_idle_inta", 2'b10);
    tick(); tick(); tick();
    check("e_inta_hold", 64'({m1_inta_o, m0_inta_o}), 64'(2'b10));
    inta = 1'b0;
    tick();

    // reset in the middle of a locked m0 transaction
    ack_en = 1'b1;
    push("f_m0_grant", 2'b01, 2'b01, 2'b00, 1, 1, 1, 3'd5, 8'h77, 8'hC3, 8'h00, 2'b00);
    set_m0(1, 1, 1, 3'd5, 8'h77, 1);
    tick(); tick();
    set_m0(0, 0, 1, 3'd5, 8'h77, 1);
    tick();
    ack_en = 1'b0;
    set_m0(1, 1, 1, 3'd5, 8'h77, 1);
    rst = 1'b1;
    push_idle("f_reset_idle", 2'b00);
    tick();
    rst = 1'b0;
    set_m0(0, 0, 0, 3'd0, 8'h00, 0);
    tick(); tick(); tick();

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
